uart_rx_clk_div: RTL and testbench



---
 rtl/uart_rx_clk_div_pkg.sv | 20 ++
 rtl/uart_rx_clk_div_clk_mux.sv | 18 +
 rtl/uart_rx_clk_div.sv | 102 ++++++++++
 tb/tb_uart_rx_clk_div.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_clk_div_pkg.sv
// +--------------------------------------------------------------------+
// | uart_rx_clk_pkg : shared types/constants for the UART RX divider   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_rx_clk_pkg;

  localparam int unsigned RATIO_WIDTH_DEF  = 8;
  localparam int unsigned RATIO_BYPASS_MAX = 1;
  localparam int unsigned RATIO_MIN_DIV    = 2;

  typedef enum logic {
    BYPASS = 1'b0,
    DIVIDE = 1'b1
  } clk_div_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_clk_div_clk_mux.sv
// +--------------------------------------------------------------------+
// | clk_mux_2to1 : isolated clock select, mapped to a clock-mux cell   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module clk_mux_2to1 (
  input  logic i_clk0,
  input  logic i_clk1,
  input  logic i_sel,
  output logic o_clk
);

  assign o_clk = i_sel ? i_clk1 : i_clk0;

endmodule

`default_nettype wire

// File: rtl/uart_rx_clk_div.sv
// +--------------------------------------------------------------------+
// | uart_rx_clk_div : integer divider producing the UART RX clock      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_clk_div
  import uart_rx_clk_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = RATIO_WIDTH_DEF
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_clk_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  output logic                   o_div_clk,
  output logic                   o_div_tick
);

  localparam logic [RATIO_WIDTH-1:0] c_ONE       = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] c_RATIO_MIN = RATIO_WIDTH'(RATIO_MIN_DIV);

  clk_div_state_e         state_q, state_d;
  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATIO_WIDTH-1:0] n_lat_q, n_lat_d;
  logic                   div_q, div_d;

  logic [RATIO_WIDTH-1:0] w_cnt_next;
  logic                   w_ratio_ok;
  logic                   w_in_div;
  logic                   w_ref_gated;

  assign w_ratio_ok = (i_div_ratio >= c_RATIO_MIN);

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= BYPASS;
      cnt_q   <= '0;
      n_lat_q <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_lat_q <= n_lat_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_lat_d    = n_lat_q;
    div_d      = div_q;
    w_cnt_next = (cnt_q == n_lat_q - c_ONE) ? '0 : cnt_q + c_ONE;
    case (state_q)
      BYPASS: begin
        if (i_clk_en && w_ratio_ok) begin
          state_d = DIVIDE;
          n_lat_d = i_div_ratio;
          cnt_d   = '0;
          div_d   = 1'b1;
        end
      end
      DIVIDE: begin
        // Enable drop leaves at once; ratio changes only land on a period boundary.
        if (!i_clk_en) begin
          state_d = BYPASS;
          cnt_d   = '0;
          div_d   = 1'b0;
        end else begin
          cnt_d = w_cnt_next;
          div_d = (w_cnt_next < (n_lat_q >> 1));
          if (w_cnt_next == '0) begin
            if (w_ratio_ok) begin
              n_lat_d = i_div_ratio;
            end else begin
              state_d = BYPASS;
              cnt_d   = '0;
              div_d   = 1'b0;
            end
          end
        end
      end
    endcase
  end

  assign w_in_div    = (state_q == DIVIDE);
  // Reset forces the bypassed clock low as well as the divided one.
  assign w_ref_gated = i_ref_clk & ~i_rst;

  clk_mux_2to1 u_clk_mux (
    .i_clk0 (w_ref_gated),
    .i_clk1 (div_q),
    .i_sel  (w_in_div),
    .o_clk  (o_div_clk)
  );

  assign o_div_tick = w_in_div ? (cnt_q == '0) : (i_clk_en & ~i_rst);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_clk_div.sv
// +--------------------------------------------------------------------+
// | tb_uart_rx_clk_div : self-checking bench for uart_rx_clk_div       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_clk_div;

  logic       ref_clk;
  logic       rst;
  logic       en;
  logic [7:0] ratio;
  logic       div_clk;
  logic       div_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: divided-clock mode flag, period N, position within period.
  bit m_div = 1'b0;
  int m_n   = 0;
  int m_p   = 0;

  logic hi_clk, hi_tick, lo_clk;

  typedef struct {
    bit en;
    int ratio;
    bit hi;
    bit lo;
    bit tk;
  } vec_t;

  vec_t tbl[$];

  uart_rx_clk_div #(.RATIO_WIDTH(8)) dut (
    .i_ref_clk   (ref_clk),
    .i_rst       (rst),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (div_clk),
    .o_div_tick  (div_tick)
  );

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_div = 1'b0;
    m_n   = 0;
    m_p   = 0;
  endfunction

  function automatic void model_step();
    int r;
    r = int'(ratio);
    if (!m_div) begin
      if (en && r >= 2) begin
        m_div = 1'b1;
        m_n   = r;
        m_p   = 0;
      end
    end else if (!en) begin
      m_div = 1'b0;
    end else begin
      m_p = m_p + 1;
      if (m_p == m_n) begin
        m_p = 0;
        if (r >= 2) m_n = r;
        else        m_div = 1'b0;
      end
    end
  endfunction

  function automatic logic model_clk(input bit high_phase);
    if (rst)   return 1'b0;
    if (m_div) return (m_p < m_n / 2);
    return high_phase;
  endfunction

  function automatic logic model_tick();
    if (rst)   return 1'b0;
    if (m_div) return (m_p == 0);
    return en;
  endfunction

  // One reference cycle: model advances on the edge, outputs checked in both phases.
  task automatic cycle();
    @(posedge ref_clk);
    if (!rst) model_step();
    #1;
    hi_clk  = div_clk;
    hi_tick = div_tick;
    chk("model_clk_hi", div_clk, model_clk(1'b1));
    chk("model_tick", div_tick, model_tick());
    @(negedge ref_clk);
    #1;
    lo_clk = div_clk;
    chk("model_clk_lo", div_clk, model_clk(1'b0));
  endtask

  task automatic run_pattern(input int n, input int periods);
    en    = 1'b1;
    ratio = 8'(n);
    for (int k = 0; k < n * periods; k++) begin
      cycle();
      chk("pat_clk", hi_clk, logic'((k % n) < (n / 2)));
      chk("pat_tick", hi_tick, logic'((k % n) == 0));
    end
    en = 1'b0;
    cycle();
  endtask

  initial begin
    int hi_cnt;
    int lo_cnt;
    rst   = 1'b1;
    en    = 1'b0;
    ratio = 8'd0;

    // Reset state, including with enable high.
    @(posedge ref_clk); #1;
    chk("rst_clk_hi", div_clk, 1'b0);
    chk("rst_tick", div_tick, 1'b0);
    en    = 1'b1;
    ratio = 8'd1;
    #1;
    chk("rst_tick_en", div_tick, 1'b0);
    @(negedge ref_clk); #1;
    chk("rst_clk_lo", div_clk, 1'b0);
    rst = 1'b0;
    model_reset();

    // Directed table: bypass, N=4 entry, mid-period change to 2, change to 1, enable low.
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      en    = tbl[i].en;
      ratio = 8'(tbl[i].ratio);
      cycle();
      chk($sformatf("tbl%0d_clk_hi", i), hi_clk, tbl[i].hi);
      chk($sformatf("tbl%0d_clk_lo", i), lo_clk, tbl[i].lo);
      chk($sformatf("tbl%0d_tick", i), hi_tick, tbl[i].tk);
    end

    // Ten periods each of N=4 and N=5.
    run_pattern(4, 10);
    run_pattern(5, 10);

    // Enable drop mid-period at cnt=2, then re-enable with N=8.
    en    = 1'b1;
    ratio = 8'd4;
    cycle();
    cycle();
    cycle();
    en = 1'b0;
    cycle();
    chk("drop_clk_hi", hi_clk, 1'b1);
    chk("drop_clk_lo", lo_clk, 1'b0);
    chk("drop_tick", hi_tick, 1'b0);
    run_pattern(8, 2);

    // Randomized traffic against the model.
    en    = 1'b0;
    ratio = 8'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 7))
          0: ratio = 8'd0;
          1: ratio = 8'd1;
          2: ratio = 8'd2;
          3: ratio = 8'd3;
          4: ratio = 8'd5;
          5: ratio = 8'd8;
          6: ratio = 8'd255;
          default: ratio = 8'($urandom_range(2, 40));
        endcase
      end
      if (en) begin
        if ($urandom_range(0, 63) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      cycle();
    end

    // Mid-operation reset at cnt=100 with N=255.
    en = 1'b0;
    cycle();
    en    = 1'b1;
    ratio = 8'd255;
    cycle();
    for (int k = 0; k < 100; k++) cycle();
    chk("pre_rst_clk", div_clk, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_clk", div_clk, 1'b0);
    chk("async_rst_tick", div_tick, 1'b0);
    @(posedge ref_clk); #1;
    chk("in_rst_clk_hi", div_clk, 1'b0);
    @(negedge ref_clk); #1;
    rst = 1'b0;
    model_reset();

    // Max ratio after release: 127 high, 128 low.
    hi_cnt = 0;
    lo_cnt = 0;
    for (int k = 0; k < 255; k++) begin
      cycle();
      if (hi_clk === 1'b1) hi_cnt++;
      else                 lo_cnt++;
    end
    chk_int("max_high_cycles", hi_cnt, 127);
    chk_int("max_low_cycles", lo_cnt, 128);
    cycle();
    chk("max_wrap_tick", hi_tick, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
